// File: rtl/ssd_status_if.sv
// Game-status display bus: BCD score/lives from the game controller in,
// active-low anode/segment drive and the game-over flag out.
interface ssd_status_if;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [3:0] lives;
    logic [7:0] an;
    logic [7:0] ssd;
    logic       game_over;

    modport master (
        output score_ones, score_tens, lives,
        input  an, ssd, game_over
    );

    modport slave (
        input  score_ones, score_tens, lives,
        output an, ssd, game_over
    );
endinterface

// File: rtl/ssd_status_driver.sv
// Four-digit multiplexed score/lives display with life-lost blink and game-over dashes.
// Optional macro SSD_LEADING_ZERO_BLANK_EN blanks a zero tens digit outside game over.
module ssd_status_driver #(
    parameter int REFRESH_BITS = 18,
    parameter int BLINK_BITS   = 24
) (
    input logic          clk,
    input logic          rst,
    ssd_status_if.slave  bus
);

    typedef enum logic [1:0] {RUN, BLINK, OVER} state_e;

    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

    state_e                  state_q, state_d;
    logic [3:0]              ones_q, ones_d;
    logic [3:0]              tens_q, tens_d;
    logic [3:0]              lives_q, lives_d;
    logic [3:0]              lives_prev_q, lives_prev_d;
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [BLINK_BITS-1:0]   blink_q, blink_d;
    logic [7:0]              an_q, an_d;
    logic [7:0]              ssd_q, ssd_d;

    logic [1:0] digit;
    logic [3:0] digit_val;
    logic       lives_drop;

    function automatic logic [7:0] seg_encode(input logic [3:0] v);
        case (v)
            4'd0:    seg_encode = 8'b0000_0011;
            4'd1:    seg_encode = 8'b1001_1111;
            4'd2:    seg_encode = 8'b0010_0101;
            4'd3:    seg_encode = 8'b0000_1101;
            4'd4:    seg_encode = 8'b1001_1001;
            4'd5:    seg_encode = 8'b0100_1001;
            4'd6:    seg_encode = 8'b0100_0001;
            4'd7:    seg_encode = 8'b0001_1111;
            4'd8:    seg_encode = 8'b0000_0001;
            4'd9:    seg_encode = 8'b0000_1001;
            default: seg_encode = 8'b0110_0001;
        endcase
    endfunction

    // Lives reset to 9 so releasing rst can never look like a lost life or game over.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            lives_q      <= 4'd9;
            lives_prev_q <= 4'd9;
            scan_q       <= '0;
            blink_q      <= '0;
            an_q         <= 8'hFF;
            ssd_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            lives_q      <= lives_d;
            lives_prev_q <= lives_prev_d;
            scan_q       <= scan_d;
            blink_q      <= blink_d;
            an_q         <= an_d;
            ssd_q        <= ssd_d;
        end
    end

    assign lives_drop = (lives_q < lives_prev_q);

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        ones_d       = bus.score_ones;
        tens_d       = bus.score_tens;
        lives_d      = bus.lives;
        lives_prev_d = lives_q;
        scan_d       = scan_q + 1'b1;
        state_d      = state_q;
        blink_d      = blink_q;

        if (lives_q == 4'd0) begin
            state_d = OVER;
        end else begin
            case (state_q)
                RUN: begin
                    if (lives_drop) begin
                        state_d = BLINK;
                        blink_d = '1;
                    end
                end
                BLINK: begin
                    if (lives_drop) begin
                        blink_d = '1;
                    end else if (blink_q == '0) begin
                        state_d = RUN;
                    end else begin
                        blink_d = blink_q - 1'b1;
                    end
                end
                default: state_d = OVER;
            endcase
        end
    end

    assign digit = scan_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        an_d      = 8'hFF;
        digit_val = 4'd0;
        case (digit)
            2'd0: begin an_d = 8'hFE; digit_val = ones_q;  end
            2'd1: begin an_d = 8'hFD; digit_val = tens_q;  end
            2'd2: begin an_d = 8'hFB; digit_val = 4'd0;    end
            default: begin an_d = 8'hF7; digit_val = lives_q; end
        endcase

        ssd_d = seg_encode(digit_val);
        if (digit == 2'd2) begin
            ssd_d = SEG_BLANK;
        end
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (digit == 2'd1 && tens_q == 4'd0) begin
            ssd_d = SEG_BLANK;
        end
`endif
        if (digit == 2'd3 && state_q == BLINK && blink_q[BLINK_BITS-3]) begin
            ssd_d = SEG_BLANK;
        end
        if (state_q == OVER) begin
            ssd_d = SEG_DASH;
        end
    end

    assign bus.an        = an_q;
    assign bus.ssd       = ssd_q;
    assign bus.game_over = (state_q == OVER);

endmodule

// File: tb/tb_ssd_status_driver.sv
// Bench for ssd_status_driver: table of display vectors plus hand-written
// blink / game-over / reset sequences, all checked through an expectation queue.
module tb_ssd_status_driver;

    localparam int RB = 4;
    localparam int BB = 6;

    typedef enum int {M_RUN, M_BLINK, M_OVER} mode_e;

    typedef struct {
        logic [7:0] an;
        logic [7:0] ssd;
        logic       go;
    } exp_t;

    typedef struct {
        logic [3:0] ones;
        logic [3:0] tens;
        logic [7:0] exp_ones;
        logic [7:0] exp_tens;
    } vec_t;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] TENS_ZERO = 8'hFF;
`else
    localparam logic [7:0] TENS_ZERO = 8'h03;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    ssd_status_if bus();

    ssd_status_driver #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle number since the most recent reset release; output of edge n is cycle n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 8'h03;
            4'd1: return 8'h9F;
            4'd2: return 8'h25;
            4'd3: return 8'h0D;
            4'd4: return 8'h99;
            4'd5: return 8'h49;
            4'd6: return 8'h41;
            4'd7: return 8'h1F;
            4'd8: return 8'h01;
            4'd9: return 8'h09;
            default: return 8'h61;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue n cycles of expected display, then compare them one per cycle.
    // For M_BLINK, bstart is the blink count seen by the first cycle.
    task automatic run_window(input int n, input logic [7:0] s_ones, input logic [7:0] s_tens,
                              input logic [7:0] s_lives, input mode_e m, input int bstart);
        int base;
        base = cyc;
        for (int i = 0; i < n; i++) begin
            exp_t       e;
            int         cycle;
            int         idx;
            int         b;
            mode_e      mm;
            logic [7:0] sel;
            cycle = base + 1 + i;
            idx   = ((cycle - 1) >> 2) & 3;
            sel   = 8'h01 << idx;
            e.an  = ~sel;
            b     = bstart - i;
            mm    = m;
            if (m == M_BLINK && b < 0) mm = M_RUN;
            case (idx)
                0: e.ssd = s_ones;
                1: e.ssd = s_tens;
                2: e.ssd = 8'hFF;
                default: e.ssd = (mm == M_BLINK && ((b >> 3) & 1) == 1) ? 8'hFF : s_lives;
            endcase
            if (mm == M_OVER) e.ssd = 8'hFD;
            e.go = (m == M_OVER);
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            exp_t e;
            tick();
            e = sb.pop_front();
            check("an", bus.an, e.an);
            check("ssd", bus.ssd, e.ssd);
            check("game_over", {7'd0, bus.game_over}, {7'd0, e.go});
        end
    endtask

    initial begin
        vecs[0] = '{ones: 4'd4, tens: 4'd2, exp_ones: 8'h99, exp_tens: 8'h25};
        vecs[1] = '{ones: 4'hC, tens: 4'd7, exp_ones: 8'h61, exp_tens: 8'h1F};
        vecs[2] = '{ones: 4'd0, tens: 4'd0, exp_ones: 8'h03, exp_tens: TENS_ZERO};
        vecs[3] = '{ones: 4'd8, tens: 4'd5, exp_ones: 8'h01, exp_tens: 8'h49};
        vecs[4] = '{ones: 4'd3, tens: 4'd6, exp_ones: 8'h0D, exp_tens: 8'h41};
        vecs[5] = '{ones: 4'd1, tens: 4'hF, exp_ones: 8'h9F, exp_tens: 8'h61};

        bus.score_ones = 4'd4;
        bus.score_tens = 4'd2;
        bus.lives      = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", bus.an, 8'hFF);
        check("rst_ssd", bus.ssd, 8'hFF);
        check("rst_game_over", {7'd0, bus.game_over}, 8'h00);

        // First post-release cycle still shows reset-captured ones value 0.
        rst = 1'b0;
        tick();
        check("first_an", bus.an, 8'hFE);
        check("first_ssd", bus.ssd, 8'h03);
        run_window(16, 8'h99, 8'h25, 8'h09, M_RUN, 0);

        foreach (vecs[k]) begin
            bus.score_ones = vecs[k].ones;
            bus.score_tens = vecs[k].tens;
            tick();
            run_window(16, vecs[k].exp_ones, vecs[k].exp_tens, seg_of(4'd9), M_RUN, 0);
        end

        bus.score_ones = 4'd4;
        bus.score_tens = 4'd2;
        repeat (3) tick();

        // Single life lost: full blink episode, then normal display again.
        bus.lives = 4'd8;
        repeat (2) tick();
        run_window(70, 8'h99, 8'h25, 8'h01, M_BLINK, 63);

        // Lives going up never blinks.
        bus.lives = 4'd9;
        tick();
        run_window(16, 8'h99, 8'h25, 8'h09, M_RUN, 0);

        // Second loss inside a blink reloads the counter.
        bus.lives = 4'd8;
        repeat (2) tick();
        run_window(20, 8'h99, 8'h25, 8'h01, M_BLINK, 63);
        bus.lives = 4'd7;
        repeat (2) tick();
        run_window(30, 8'h99, 8'h25, 8'h1F, M_BLINK, 63);

        // Out of lives: game over one cycle after the 0 is captured, then sticky.
        bus.lives = 4'd0;
        tick();
        check("go_before_over", {7'd0, bus.game_over}, 8'h00);
        tick();
        check("go_at_over", {7'd0, bus.game_over}, 8'h01);
        run_window(20, 8'h99, 8'h25, 8'h03, M_OVER, 0);
        bus.lives = 4'd5;
        run_window(20, 8'h99, 8'h25, 8'h49, M_OVER, 0);

        // Reset pulse in game over returns to a normal scan from digit 0.
        bus.lives = 4'd9;
        rst = 1'b1;
        #1;
        check("rst2_an", bus.an, 8'hFF);
        check("rst2_ssd", bus.ssd, 8'hFF);
        check("rst2_game_over", {7'd0, bus.game_over}, 8'h00);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst2_first_an", bus.an, 8'hFE);
        check("rst2_first_go", {7'd0, bus.game_over}, 8'h00);
        run_window(16, 8'h99, 8'h25, 8'h09, M_RUN, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
